// File: rtl/la_ctrl_pkg.sv
// Shared definitions for the LA counter arbiter: register map,
// field indices, bus FSM states and a byte-lane merge helper.
package la_ctrl_pkg;

   localparam logic [3:0] OFF_CTRL    = 4'h0;
   localparam logic [3:0] OFF_COUNT   = 4'h4;
   localparam logic [3:0] OFF_COMPARE = 4'h8;
   localparam logic [3:0] OFF_STATUS  = 4'hC;

   localparam int CTRL_RUN    = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_PRESC  = 8;

   localparam int ST_MATCH  = 0;
   localparam int ST_COLL   = 1;
   localparam int ST_WRAP   = 2;
   localparam int ST_LA_OWN = 3;

   typedef enum logic {
      S_IDLE,
      S_ACK
   } bus_state_t;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/la_counter_core.sv
// Counter datapath: LA override, bus load, prescaled increment,
// plus wrap and compare-match event detection.
module la_counter_core
   import la_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic [PRESC_W-1:0] presc,
   input  logic [WIDTH-1:0]   la_mask,
   input  logic [WIDTH-1:0]   la_val,
   input  logic               wb_load,
   input  logic [WIDTH-1:0]   wb_val,
   input  logic [WIDTH-1:0]   compare,
   output logic [WIDTH-1:0]   count_o,
   output logic               wrap_set,
   output logic               match_set
);

   logic [WIDTH-1:0]   count_q, count_d;
   logic [PRESC_W-1:0] pre_q, pre_d;
   logic               eq_q, eq_d;

   always_comb begin
      count_d  = count_q;
      pre_d    = pre_q;
      wrap_set = 1'b0;
      if (|la_mask) begin
         count_d = (count_q & ~la_mask) | (la_val & la_mask);
      end else if (wb_load) begin
         count_d = wb_val;
         pre_d   = '0;
      end else if (run) begin
         // >= so a presc lowered mid-count cannot strand the prescaler
         if (pre_q >= presc) begin
            count_d  = count_q + 1'b1;
            pre_d    = '0;
            wrap_set = &count_q;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
      eq_d      = (count_d == compare);
      match_set = eq_d & ~eq_q;
   end

   // eq_q resets to 1: count and COMPARE both reset to 0 (already equal)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         pre_q   <= '0;
         eq_q    <= 1'b1;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         eq_q    <= eq_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/la_counter_arbiter.sv
// Wishbone register file and bus FSM around the LA-controlled
// counter; mirrors count and status onto the LA outputs.
module la_counter_arbiter
   import la_ctrl_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          PRESC_W  = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rstn_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [63:0]      la_data_in,
   input  logic [63:0]      la_oenb,
   output logic [63:0]      la_data_out,
   output logic [WIDTH-1:0] count_o,
   output logic             irq_o
);

   bus_state_t         state_q, state_d;
   logic               run_q, irq_en_q, irq_q;
   logic [PRESC_W-1:0] presc_q;
   logic [WIDTH-1:0]   cmp_q, cmp_d;
   logic [2:0]         st_q, st_d, st_set, w1c;
   logic [31:0]        dat_q;

   logic               hit, wr;
   logic               is_ctrl, is_cnt, is_cmp, is_st;
   logic [1:0]         word;
   logic [31:0]        ctrl_word, stat_word, rd_word, wr_word;
   logic [WIDTH-1:0]   la_mask, count;
   logic               la_own, cnt_load, wrap_set, match_set;
   logic               unused_bits;

   assign la_mask = ~la_oenb[32 +: WIDTH];
   assign la_own  = |la_mask;

   assign word    = wbs_adr_i[3:2];
   assign is_ctrl = (word == OFF_CTRL[3:2]);
   assign is_cnt  = (word == OFF_COUNT[3:2]);
   assign is_cmp  = (word == OFF_COMPARE[3:2]);
   assign is_st   = (word == OFF_STATUS[3:2]);

   assign hit = (state_q == S_IDLE) & wbs_cyc_i & wbs_stb_i &
                (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign wr  = hit & wbs_we_i;

   always_comb begin
      ctrl_word                         = '0;
      ctrl_word[CTRL_RUN]               = run_q;
      ctrl_word[CTRL_IRQ_EN]            = irq_en_q;
      ctrl_word[CTRL_PRESC +: PRESC_W]  = presc_q;
      stat_word                         = '0;
      stat_word[ST_WRAP:ST_MATCH]       = st_q;
      stat_word[ST_LA_OWN]              = la_own;
   end

   always_comb begin
      rd_word = '0;
      unique case (1'b1)
         is_ctrl: rd_word = ctrl_word;
         is_cnt:  rd_word = 32'(count);
         is_cmp:  rd_word = 32'(cmp_q);
         is_st:   rd_word = stat_word;
         default: rd_word = '0;
      endcase
   end

   // unselected byte lanes keep the addressed register's current value
   assign wr_word = byte_merge(rd_word, wbs_dat_i, wbs_sel_i);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (hit) state_d = S_ACK;
         S_ACK:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign cnt_load = wr & is_cnt;
   assign cmp_d    = (wr & is_cmp) ? wr_word[WIDTH-1:0] : cmp_q;
   assign w1c      = (wr & is_st & wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b0;
   assign st_set   = {wrap_set, cnt_load & la_own, match_set};
   assign st_d     = (st_q & ~w1c) | st_set;

   la_counter_core #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
   ) u_core (
      .clk       (wb_clk_i),
      .rst_n     (wb_rstn_i),
      .run       (run_q),
      .presc     (presc_q),
      .la_mask   (la_mask),
      .la_val    (la_data_in[32 +: WIDTH]),
      .wb_load   (cnt_load),
      .wb_val    (wr_word[WIDTH-1:0]),
      .compare   (cmp_d),
      .count_o   (count),
      .wrap_set  (wrap_set),
      .match_set (match_set)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q  <= S_IDLE;
         run_q    <= 1'b0;
         irq_en_q <= 1'b0;
         presc_q  <= '0;
         cmp_q    <= '0;
         st_q     <= '0;
         irq_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q <= state_d;
         cmp_q   <= cmp_d;
         st_q    <= st_d;
         irq_q   <= st_q[ST_MATCH] & irq_en_q;
         if (hit) dat_q <= rd_word;
         if (wr & is_ctrl) begin
            run_q    <= wr_word[CTRL_RUN];
            irq_en_q <= wr_word[CTRL_IRQ_EN];
            presc_q  <= wr_word[CTRL_PRESC +: PRESC_W];
         end
      end
   end

   assign wbs_ack_o   = (state_q == S_ACK);
   assign wbs_dat_o   = dat_q;
   assign count_o     = count;
   assign irq_o       = irq_q;
   assign la_data_out = {28'b0, stat_word[3:0], 32'(count)};

   assign unused_bits = ^{la_data_in, la_oenb, wbs_adr_i[1:0], wr_word};

endmodule
